// File: rtl/down_counter.sv
// Loadable down-counter/timer: accepts a count over a valid/ready handshake,
// decrements on enable and pulses done on expiry, optionally auto-reloading.
module down_counter #(
  parameter int SIZE   = 8,
  parameter bit RELOAD = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] load_value,
  input  logic            enable,
  input  logic            clear,
  output logic [SIZE-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [1:0]      fsm_state
);

  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;

  localparam logic [SIZE-1:0] ZERO = '0;
  localparam logic [SIZE-1:0] ONE  = {{(SIZE-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [SIZE-1:0] period;

  // Handshake: a load fires on a rising edge where load_valid && load_ready.
  // load_ready depends only on state and clear, never on load_valid.
  assign load_ready = (state == IDLE) && !clear;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      value  <= ZERO;
      period <= ZERO;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        value  <= ZERO;
        period <= ZERO;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              if (load_value == ZERO) begin
                // Zero-length run expires immediately without leaving IDLE.
                done   <= 1'b1;
                period <= ZERO;
                value  <= ZERO;
              end else begin
                value  <= load_value;
                period <= load_value;
                state  <= RUN;
                busy   <= 1'b1;
              end
            end
          end
          RUN: begin
            if (enable) begin
              if (value > ONE) begin
                value <= value - ONE;
              end else if (value == ONE) begin
                done <= 1'b1;
                if (RELOAD) begin
                  value <= period;
                end else begin
                  value <= ZERO;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                // Unreachable zero count in RUN: recover quietly.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            value  <= ZERO;
            period <= ZERO;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: one-shot and auto-reload instances share stimulus and
// are compared each cycle against a count-based reference model.
module tb_down_counter;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] load_value;
  logic       enable;
  logic       clear;

  logic       load_ready [2];
  logic [7:0] value_o    [2];
  logic       busy_o     [2];
  logic       done_o     [2];
  logic [1:0] state_o    [2];

  int errors = 0;
  int checks = 0;

  // Reference: remaining count, stored period, running flag, pending pulse.
  int m_val  [2];
  int m_per  [2];
  bit m_run  [2];
  bit m_done [2];

  down_counter #(.SIZE(8), .RELOAD(1'b0)) u_oneshot (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid),
    .load_ready(load_ready[0]), .load_value(load_value), .enable(enable),
    .clear(clear), .value(value_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .fsm_state(state_o[0])
  );

  down_counter #(.SIZE(8), .RELOAD(1'b1)) u_reload (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid),
    .load_ready(load_ready[1]), .load_value(load_value), .enable(enable),
    .clear(clear), .value(value_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .fsm_state(state_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_val[r] = 0; m_per[r] = 0; m_run[r] = 0; m_done[r] = 0;
    end
  endtask

  task automatic model_step();
    for (int r = 0; r < 2; r++) begin
      m_done[r] = 0;
      if (clear) begin
        m_val[r] = 0; m_per[r] = 0; m_run[r] = 0;
      end else if (!m_run[r]) begin
        if (load_valid) begin
          m_per[r] = int'(load_value);
          if (load_value == 0) m_done[r] = 1;
          else begin m_val[r] = int'(load_value); m_run[r] = 1; end
        end
      end else if (enable) begin
        if (m_val[r] > 1) m_val[r] = m_val[r] - 1;
        else begin
          m_done[r] = 1;
          if (r == 1) m_val[r] = m_per[r];
          else begin m_val[r] = 0; m_run[r] = 0; end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int r = 0; r < 2; r++) begin
      check($sformatf("value[%0d]", r), 32'(value_o[r]), 32'(m_val[r]));
      check($sformatf("busy[%0d]", r), 32'(busy_o[r]), 32'(m_run[r]));
      check($sformatf("done[%0d]", r), 32'(done_o[r]), 32'(m_done[r]));
    end
  endtask

  // Inputs are set by the caller; one rising edge is consumed.
  task automatic tick();
    #1;
    for (int r = 0; r < 2; r++)
      check($sformatf("load_ready[%0d]", r), 32'(load_ready[r]), 32'(!m_run[r] && !clear));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit lv, input int val, input bit en, input bit clr);
    load_valid = lv;
    load_value = 8'(val);
    enable     = en;
    clear      = clr;
  endtask

  initial begin
    int cyc;
    int pulses;
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();

    // Reset values while reset is held, then release mid-cycle.
    #3;
    check_outputs();
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    // One-shot of 5: done arrives with value 0 on the 6th edge counting the load.
    drive(1, 5, 1, 0); tick();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    check("os5_value", 32'(value_o[0]), 32'd0);
    check("os5_done", 32'(done_o[0]), 32'd1);
    check("os5_busy", 32'(busy_o[0]), 32'd0);
    drive(0, 0, 0, 1); tick();

    // Load 255 with enable toggling (low first): 255 enabled edges span 510 edges.
    drive(1, 255, 0, 0); tick();
    cyc = 0;
    for (int i = 1; i <= 600; i++) begin
      drive(0, 0, (i % 2) == 0, 0);
      tick();
      if (done_o[0]) begin cyc = i; break; end
      cyc = i + 1;
    end
    check("ld255_edges", 32'(cyc), 32'd510);
    drive(0, 0, 0, 1); tick();

    // Zero load: done next cycle, never busy.
    drive(1, 0, 1, 0); tick();
    check("zero_done", 32'(done_o[0]), 32'd1);
    check("zero_busy", 32'(busy_o[1]), 32'd0);
    drive(0, 0, 1, 0); tick();

    // Reload of 3 over 12 enabled edges gives four done pulses.
    drive(1, 3, 1, 0); tick();
    pulses = 0;
    drive(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_o[1]) pulses++;
    end
    check("reload_pulses", 32'(pulses), 32'd4);
    check("reload_busy", 32'(busy_o[1]), 32'd1);
    drive(0, 0, 0, 1); tick();

    // Load 9 held during a run of 4 is ignored, then taken in the done cycle.
    drive(1, 4, 1, 0); tick();
    drive(1, 9, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    check("b2b_done", 32'(done_o[0]), 32'd1);
    tick();
    check("b2b_value", 32'(value_o[0]), 32'd9);
    check("b2b_busy", 32'(busy_o[0]), 32'd1);
    drive(0, 0, 0, 1); tick();

    // Clear at value 2 aborts without a pulse.
    drive(1, 4, 1, 0); tick();
    drive(0, 0, 1, 0); tick(); tick();
    check("pre_clear", 32'(value_o[0]), 32'd2);
    drive(0, 0, 1, 1); tick();
    check("clear_value", 32'(value_o[0]), 32'd0);
    check("clear_done", 32'(done_o[0]), 32'd0);

    // Clear together with a load in IDLE: not ready, no load.
    drive(1, 9, 1, 1); tick();
    check("clr_ld_value", 32'(value_o[0]), 32'd0);
    drive(0, 0, 0, 0); tick();

    // Reset mid-run at value 7: immediate zeros, no pulse.
    drive(1, 8, 1, 0); tick();
    drive(0, 0, 1, 0); tick();
    check("pre_rst", 32'(value_o[0]), 32'd7);
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) == 0,
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
